// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 serial transmitter with a small byte FIFO in front of
// the bit engine. Idle line is high; each frame is one start bit (0), DATA_BITS
// data bits LSB first, and one stop bit (1). Back-to-back queued bytes are sent
// with no idle gap between frames.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 15,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          data_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic [CLK_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 data_out_q, data_out_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 push, pop, fifo_empty;

  // Ready depends only on the registered count, so a pop on a full edge
  // never opens a slot for a push on that same edge.
  assign tx_ready   = (cnt_q != CNT_FULL);
  assign fifo_empty = (cnt_q == '0);
  assign push       = tx_valid && tx_ready;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign fifo_cnt   = cnt_q;
  assign data_out   = data_out_q;

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO control: pointers wrap naturally because the depth is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage holds its own copy of each accepted byte.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // Bit engine next state. data_out_d is the level for the coming cycle, so
  // the registered line changes on exactly the same edge as the state.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        data_out_d = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = mem_q[rd_ptr_q];
          clk_cnt_d  = '0;
          data_out_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d  = '0;
          bit_idx_d  = '0;
          data_out_d = shift_q[0];
          state_d    = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            data_out_d = 1'b1;
            state_d    = STOP;
          end else begin
            shift_d    = shift_q >> 1;
            bit_idx_d  = bit_idx_q + BIT_W'(1);
            data_out_d = shift_d[0];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next frame with no idle gap.
            pop        = 1'b1;
            shift_d    = mem_q[rd_ptr_q];
            data_out_d = 1'b0;
            state_d    = START;
          end else begin
            data_out_d = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      default: begin
        data_out_d = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  // Bit engine control registers; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      data_out_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_out_q <= data_out_d;
    end
  end

  // Shift register carries the byte being serialised; only read outside IDLE.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: reset, single frames, back-to-back with a full
// FIFO, reset mid-frame and a randomized loopback into a behavioural receiver.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  localparam int CPB   = 15;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int FRAME = (DB + 2) * CPB;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef logic [DB-1:0] byte_q_t [$];

  logic          clk = 1'b0;
  logic          reset;
  logic [DB-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          data_out;
  logic          busy;
  logic [CW-1:0] fifo_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .data_out(data_out),
    .busy    (busy),
    .fifo_cnt(fifo_cnt)
  );

  // Expected line level k cycles after the first frame's start, with the
  // queued bytes sent as consecutive 8N1 frames and the line idle afterwards.
  function automatic logic exp_line(input byte_q_t q, input int k);
    int f;
    int b;
    if (k < 0) return 1'b1;
    f = k / FRAME;
    if (f >= q.size()) return 1'b1;
    b = (k % FRAME) / CPB;
    if (b == 0) return 1'b0;
    if (b == DB + 1) return 1'b1;
    return q[f][b-1];
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if ({data_out, tx_ready, busy, fifo_cnt} !== {1'b1, 1'b1, 1'b0, CW'(0)}) begin
        n_err++;
        $display("FAIL reset_hold: got out=%b rdy=%b busy=%b cnt=%0d, want 1 1 0 0",
                 data_out, tx_ready, busy, fifo_cnt);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if ({data_out, tx_ready, busy, fifo_cnt} !== {1'b1, 1'b1, 1'b0, CW'(0)}) begin
        n_err++;
        $display("FAIL reset_release: cycle %0d got out=%b rdy=%b busy=%b cnt=%0d, want 1 1 0 0",
                 i, data_out, tx_ready, busy, fifo_cnt);
      end
    end
  endtask

  task automatic test_single();
    byte_q_t q;
    logic [DB-1:0] b;
    logic exp_busy;
    logic [CW-1:0] exp_cnt;
    for (int t = 0; t < 4; t++) begin
      b = (t == 0) ? 8'hE3 : 8'($urandom);
      q = {};
      q.push_back(b);
      for (int cyc = 0; cyc < FRAME + 6; cyc++) begin
        exp_busy = (cyc >= 1) && (cyc - 2 < FRAME);
        exp_cnt  = (cyc == 1) ? CW'(1) : CW'(0);
        n_vec++;
        if (data_out !== exp_line(q, cyc - 2)) begin
          n_err++;
          $display("FAIL single_line: byte %h cycle %0d got %b want %b",
                   b, cyc, data_out, exp_line(q, cyc - 2));
        end
        n_vec++;
        if (busy !== exp_busy || fifo_cnt !== exp_cnt) begin
          n_err++;
          $display("FAIL single_status: byte %h cycle %0d got busy=%b cnt=%0d want busy=%b cnt=%0d",
                   b, cyc, busy, fifo_cnt, exp_busy, exp_cnt);
        end
        if (cyc == 0) begin
          tx_data  = b;
          tx_valid = 1'b1;
        end else begin
          tx_valid = 1'b0;
          tx_data  = 8'($urandom);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t q;
    logic [DB-1:0] pat [5];
    logic [DB-1:0] extra;
    int mcnt;
    int k;
    logic acc;
    logic pp;
    logic exp_busy;
    pat   = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h00};
    pat[4] = 8'($urandom);
    extra = 8'($urandom);
    mcnt  = 0;
    q     = {};
    for (int cyc = 0; cyc < 2 + 5 * FRAME + 6; cyc++) begin
      k = cyc - 2;
      exp_busy = (mcnt != 0) || (k >= 0 && k < q.size() * FRAME);
      n_vec++;
      if (data_out !== exp_line(q, k)) begin
        n_err++;
        $display("FAIL b2b_line: cycle %0d got %b want %b", cyc, data_out, exp_line(q, k));
      end
      n_vec++;
      if (fifo_cnt !== CW'(mcnt) || tx_ready !== (mcnt != DEPTH)) begin
        n_err++;
        $display("FAIL b2b_fifo: cycle %0d got cnt=%0d rdy=%b want cnt=%0d rdy=%b",
                 cyc, fifo_cnt, tx_ready, mcnt, (mcnt != DEPTH));
      end
      n_vec++;
      if (busy !== exp_busy) begin
        n_err++;
        $display("FAIL b2b_busy: cycle %0d got %b want %b", cyc, busy, exp_busy);
      end
      if (cyc < 5) begin
        tx_valid = 1'b1;
        tx_data  = pat[cyc];
      end else if (cyc < 10) begin
        tx_valid = 1'b1;
        tx_data  = extra;
      end else begin
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
      end
      // Model of the coming edge: a frame begins every FRAME cycles while
      // bytes remain, and a push is taken only when the FIFO is not full.
      pp  = ((k + 1) >= 0) && (((k + 1) % FRAME) == 0) && (((k + 1) / FRAME) < q.size());
      acc = tx_valid && (mcnt != DEPTH);
      if (acc) q.push_back(tx_data);
      mcnt = mcnt + int'(acc) - int'(pp);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    byte_q_t q;
    logic [DB-1:0] b;
    q = {};
    q.push_back(8'hE3);
    for (int cyc = 0; cyc < 54; cyc++) begin
      if (cyc < 3) begin
        tx_valid = 1'b1;
        tx_data  = (cyc == 0) ? 8'hE3 : 8'($urandom);
      end else begin
        tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_vec++;
    if (data_out !== exp_line(q, 52) || fifo_cnt !== CW'(2)) begin
      n_err++;
      $display("FAIL midframe_pre: got out=%b cnt=%0d want out=%b cnt=2",
               data_out, fifo_cnt, exp_line(q, 52));
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({data_out, tx_ready, busy, fifo_cnt} !== {1'b1, 1'b1, 1'b0, CW'(0)}) begin
      n_err++;
      $display("FAIL midframe_reset: got out=%b rdy=%b busy=%b cnt=%0d want 1 1 0 0",
               data_out, tx_ready, busy, fifo_cnt);
    end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 2 * FRAME; cyc++) begin
      @(negedge clk);
      n_vec++;
      if (data_out !== 1'b1 || busy !== 1'b0 || fifo_cnt !== CW'(0)) begin
        n_err++;
        $display("FAIL midframe_after: cycle %0d got out=%b busy=%b cnt=%0d want 1 0 0",
                 cyc, data_out, busy, fifo_cnt);
      end
    end
    b = 8'($urandom);
    q = {};
    q.push_back(b);
    for (int cyc = 0; cyc < FRAME + 4; cyc++) begin
      n_vec++;
      if (data_out !== exp_line(q, cyc - 2)) begin
        n_err++;
        $display("FAIL midframe_new: byte %h cycle %0d got %b want %b",
                 b, cyc, data_out, exp_line(q, cyc - 2));
      end
      tx_valid = (cyc == 0);
      tx_data  = (cyc == 0) ? b : 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic test_loopback();
    byte_q_t sent;
    sent = {};
    fork
      begin : drv
        int n;
        for (int i = 0; i < 20; i++) begin
          tx_data  = 8'($urandom);
          tx_valid = 1'b1;
          sent.push_back(tx_data);
          n = 0;
          while (tx_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
          end
          if (n >= 5000) begin
            n_vec++;
            n_err++;
            $display("FAIL loopback_ready: byte %0d got no ready in %0d cycles, want ready", i, n);
          end
          @(negedge clk);
          tx_valid = 1'b0;
          tx_data  = 8'($urandom);
          if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 200)) @(negedge clk);
        end
      end
      begin : rx
        int n;
        logic [DB-1:0] r;
        for (int i = 0; i < 20; i++) begin
          n = 0;
          while (data_out !== 1'b0 && n < 6000) begin
            @(negedge clk);
            n++;
          end
          if (n >= 6000) begin
            n_vec++;
            n_err++;
            $display("FAIL loopback_start: byte %0d got no start bit in %0d cycles, want start", i, n);
            break;
          end
          repeat (CPB / 2) @(negedge clk);
          n_vec++;
          if (data_out !== 1'b0) begin
            n_err++;
            $display("FAIL loopback_startbit: byte %0d got %b want 0", i, data_out);
          end
          for (int j = 0; j < DB; j++) begin
            repeat (CPB) @(negedge clk);
            r[j] = data_out;
          end
          repeat (CPB) @(negedge clk);
          n_vec++;
          if (data_out !== 1'b1) begin
            n_err++;
            $display("FAIL loopback_stopbit: byte %0d got %b want 1", i, data_out);
          end
          n_vec++;
          if (r !== sent[i]) begin
            n_err++;
            $display("FAIL loopback_data: byte %0d got %h want %h", i, r, sent[i]);
          end
        end
      end
    join
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (20) @(negedge clk);
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
